// File: rtl/sensor_packetizer.sv
// rtl/sensor_packetizer.sv - captures a sensor snapshot and frames it as A5, seq, payload[, checksum] bytes
// Optional trailing checksum byte is built when SENSOR_PKT_CHECKSUM_EN is defined.
module sensor_packetizer #(
  parameter int SENSORS  = 1,
  parameter int BITWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SENSORS*BITWIDTH-1:0] sensor_data,
  input  logic                        sensor_done,
  output logic                        ack,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int TOT    = SENSORS * BITWIDTH;
  localparam int NBYTES = TOT / 8;
  localparam int CW     = $clog2(NBYTES + 1);

`ifdef SENSOR_PKT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, SEQ, PAYLOAD, CHECKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, SEQ, PAYLOAD} state_t;
`endif

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [TOT-1:0]  snap, snap_next, capture_order;
  logic [7:0]      seq, seq_next;
  logic [7:0]      data_next;
  logic            ack_next, done_next, hs;
`ifdef SENSOR_PKT_CHECKSUM_EN
  logic [7:0]      csum, csum_next;
`endif

  // Snapshot is stored in transmit order (word 0 at the top) so payload is a plain left shift.
  always_comb begin
    capture_order = '0;
    for (int k = 0; k < SENSORS; k++) begin
      capture_order[(SENSORS-1-k)*BITWIDTH +: BITWIDTH] = sensor_data[k*BITWIDTH +: BITWIDTH];
    end
  end

  assign hs = tx_valid && tx_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    snap_next  = snap;
    seq_next   = seq;
    ack_next   = 1'b0;
    done_next  = 1'b0;
    data_next  = 8'h00;
`ifdef SENSOR_PKT_CHECKSUM_EN
    csum_next  = csum;
`endif
    unique case (state)
      IDLE: begin
        if (sensor_done) begin
          state_next = HEADER;
          snap_next  = capture_order;
          cnt_next   = '0;
          ack_next   = 1'b1;
`ifdef SENSOR_PKT_CHECKSUM_EN
          csum_next  = 8'h00;
`endif
        end
      end
      HEADER: if (hs) state_next = SEQ;
      SEQ: begin
        if (hs) begin
          state_next = PAYLOAD;
`ifdef SENSOR_PKT_CHECKSUM_EN
          csum_next  = csum + seq;
`endif
        end
      end
      PAYLOAD: begin
        if (hs) begin
          snap_next = snap << 8;
`ifdef SENSOR_PKT_CHECKSUM_EN
          csum_next = csum + snap[TOT-1 -: 8];
`endif
          if (cnt == CW'(NBYTES - 1)) begin
`ifdef SENSOR_PKT_CHECKSUM_EN
            state_next = CHECKSUM;
`else
            state_next = IDLE;
            done_next  = 1'b1;
            seq_next   = seq + 8'd1;
`endif
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
`ifdef SENSOR_PKT_CHECKSUM_EN
      CHECKSUM: begin
        if (hs) begin
          state_next = IDLE;
          done_next  = 1'b1;
          seq_next   = seq + 8'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // Byte presented next cycle, chosen from the state being entered.
    unique case (state_next)
      HEADER:   data_next = 8'hA5;
      SEQ:      data_next = seq_next;
      PAYLOAD:  data_next = snap_next[TOT-1 -: 8];
`ifdef SENSOR_PKT_CHECKSUM_EN
      CHECKSUM: data_next = csum_next;
`endif
      default:  data_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      seq        <= 8'h00;
      ack        <= 1'b0;
      frame_done <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
`ifdef SENSOR_PKT_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      seq        <= seq_next;
      ack        <= ack_next;
      frame_done <= done_next;
      tx_data    <= data_next;
      tx_valid   <= (state_next != IDLE);
      busy       <= (state_next != IDLE);
`ifdef SENSOR_PKT_CHECKSUM_EN
      csum       <= csum_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    snap <= snap_next;
  end

endmodule

// File: tb/tb_sensor_packetizer.sv
// tb/tb_sensor_packetizer.sv - scoreboard bench for sensor_packetizer (default parameters)
// Expected frames are queued by the stimulus; a negedge monitor checks every accepted byte.
module tb_sensor_packetizer;

`ifdef SENSOR_PKT_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sensor_data;
  logic        sensor_done;
  logic        ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  sensor_packetizer #(.SENSORS(1), .BITWIDTH(32)) dut (
    .clk(clk), .rst(rst), .sensor_data(sensor_data), .sensor_done(sensor_done),
    .ack(ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_total = 0;
  bit   expect_fd = 0;
  bit   prev_busy = 0;
  bit   prev_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] s, input logic [31:0] d);
    logic [7:0] sum;
    sum = s;
    sb.push_back('{8'hA5, 1'b0});
    sb.push_back('{s, 1'b0});
    for (int i = 3; i >= 0; i--) begin
      sum = sum + d[i*8 +: 8];
`ifdef SENSOR_PKT_CHECKSUM_EN
      sb.push_back('{d[i*8 +: 8], 1'b0});
`else
      sb.push_back('{d[i*8 +: 8], (i == 0)});
`endif
    end
`ifdef SENSOR_PKT_CHECKSUM_EN
    sb.push_back('{sum, 1'b1});
`endif
  endtask

  task automatic capture(input logic [31:0] d);
    int n;
    sensor_data = d;
    sensor_done = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 50);
    checks++;
    if (!ack) begin
      failures++;
      $display("FAIL ack_timeout actual=0 required=1");
    end
    sensor_done = 1'b0;
    sensor_data = 32'hDEADBEEF;
  endtask

  task automatic wait_frame_done(input string name, output int n);
    n = 0;
    while (!frame_done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!frame_done) begin
      failures++;
      $display("FAIL %s frame_done timeout", name);
    end
  endtask

  // Monitor: every handshake pops one expected byte; frame_done must follow only the last one.
  always @(negedge clk) begin
    if (rst) begin
      expect_fd = 0;
    end else begin
      if (expect_fd) begin
        check("frame_done_after_last", {frame_done, tx_valid, busy}, 3'b100);
        expect_fd = 0;
      end else if (frame_done) begin
        check("frame_done_unexpected", frame_done, 1'b0);
      end
      if (ack) begin
        ack_total++;
        check("ack_while_busy_or_long", {prev_busy, prev_ack}, 2'b00);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_byte", tx_data, e.data);
          if (e.last) expect_fd = 1;
        end
      end
    end
    prev_busy = busy;
    prev_ack  = ack;
  end

  initial begin
    int n;
    int n_ack;
    rst = 1'b1;
    sensor_done = 1'b0;
    sensor_data = 32'h0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame: A5 00 01 02 03 04 [0A] on consecutive cycles.
    push_frame(8'h00, 32'h01020304);
    capture(32'h01020304);
    check("ack_header", {busy, tx_valid, tx_data}, {2'b11, 8'hA5});
    wait_frame_done("basic", n);
    check("basic_frame_cycles", n, FRAME_LEN);
    @(posedge clk); #1;

    // Backpressure on payload byte 0x02.
    push_frame(8'h01, 32'h01020304);
    capture(32'h01020304);
    n = 0;
    while (!(tx_valid && tx_data == 8'h02) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_02", tx_data, 8'h02);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {tx_valid, tx_data}, {1'b1, 8'h02});
    end
    tx_ready = 1'b1;
    wait_frame_done("backpressure", n);
    @(posedge clk); #1;

    // Checksum wrap: seq 2 + 4*0xFF = 0xFE.
    push_frame(8'h02, 32'hFFFFFFFF);
    capture(32'hFFFFFFFF);
    wait_frame_done("csum_wrap", n);
    @(posedge clk); #1;

    // Reset in PAYLOAD abandons the frame.
    push_frame(8'h03, 32'h11223344);
    capture(32'h11223344);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b0;
    check("midrst_outputs", {tx_valid, busy, frame_done}, 3'b000);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // 257 back-to-back frames with sensor_done held: seq restarts at 0 and wraps.
    for (int i = 0; i < 257; i++) push_frame(i[7:0], 32'h80402010);
    sensor_data = 32'h80402010;
    sensor_done = 1'b1;
    n_ack = 0;
    n = 0;
    while (n_ack < 257 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (ack) n_ack++;
    end
    sensor_done = 1'b0;
    check("held_ack_count", n_ack, 257);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("sb_drained", sb.size(), 0);
    check("total_acks", ack_total, 261);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_packetizer.md
# sensor_packetizer

Downstream consumer of the sensor controller. It captures one snapshot of all sensor words when the controller signals `sensor_done` and returns a one-cycle `ack`. It then serializes the snapshot into a framed byte stream (header, sequence number, payload, optional checksum) on a valid/ready byte interface toward the host link.

## Interface
- `SENSORS`, default 1: number of sensor words per snapshot; must be ≥1.
- `BITWIDTH`, default 32: width of each sensor word; must be a multiple of 8.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sensor_data`  in  SENSORS*BITWIDTH  flattened snapshot; word k occupies bits [k*BITWIDTH +: BITWIDTH].
- `sensor_done`  in  1  level; snapshot on `sensor_data` is valid while high.
- `ack`  out  1  one-cycle pulse confirming capture; the controller advances on it.
- `tx_data`  out  8  current frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when it is high together with `tx_valid`.
- `busy`  out  1  high from capture until the last byte is accepted.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is accepted.

## Operation
- Frame byte order:
  - Header `0xA5`.
  - Sequence byte `seq`.
  - Payload: word 0 first, each word MSB byte first, BITWIDTH/8 bytes per word.
  - Checksum byte, when enabled.
- Frame length is 3 + SENSORS*BITWIDTH/8 bytes with checksum, or 2 + SENSORS*BITWIDTH/8 bytes without. Defaults give 7 or 6 bytes.
- FSM states: IDLE, HEADER, SEQ, PAYLOAD, CHECKSUM.
  - IDLE → HEADER: on an edge where `sensor_done`=1. The full `sensor_data` is latched into an internal snapshot register on that edge.
  - HEADER → SEQ → PAYLOAD: each transition on handshake (`tx_valid && tx_ready`).
  - PAYLOAD: an internal byte counter runs 0..SENSORS*BITWIDTH/8−1. On handshake of the last payload byte, go to CHECKSUM, or to IDLE when the checksum is compiled out.
  - CHECKSUM → IDLE: on handshake.
- `seq` is an 8-bit frame counter. It increments modulo 256 when `frame_done` pulses and wraps 0xFF→0x00.
- Checksum is the 8-bit sum, mod 256, of the sequence byte and all payload bytes. The header is excluded.
- Checksum is accumulated as each byte is handshaken; no second pass over the data.
- `sensor_done` in any state other than IDLE is ignored: no `ack` and no re-capture. The source holds `sensor_done` until it sees `ack`.
- `sensor_data` may change freely after the capture edge. The frame always carries the latched snapshot.
- Output behaviour:
  - `tx_valid`=1 in HEADER, SEQ, PAYLOAD and CHECKSUM; 0 in IDLE.
  - `busy`=1 in every state except IDLE.
- Reset state: IDLE; `tx_valid`=0, `tx_data`=0x00, `ack`=0, `busy`=0, `frame_done`=0, `seq`=0x00, checksum accumulator 0. Snapshot contents are don't-care.
- Reset mid-frame: the frame is abandoned with no `frame_done`, and `seq` returns to 0.

## Timing
- `ack`, `busy` and `tx_valid` (with `tx_data`=0xA5) all rise in the cycle after the capture edge. `ack` is high for exactly one cycle.
- Throughput is one byte per cycle while `tx_ready`=1. A default frame with checksum occupies 7 consecutive cycles.
- Backpressure: while `tx_valid`=1 and `tx_ready`=0, `tx_data` and the state hold unchanged. `tx_valid` never drops once raised until the byte is accepted.
- `frame_done` is high, and `busy`/`tx_valid` are 0, in the cycle after the last byte's handshake.
- The earliest next capture is on the edge that ends that IDLE cycle. Minimum gap between frames is one IDLE cycle.
- All outputs are registered; no combinational path from `tx_ready` or `sensor_done` to any output.

## Configuration
- `SENSOR_PKT_CHECKSUM_EN` defined: CHECKSUM state, checksum accumulator and trailing checksum byte are present.
- Not defined: CHECKSUM state and accumulator are removed. The frame ends after the last payload byte; all other behaviour is unchanged.

## Test plan
- Basic frame (checksum on): `sensor_done`=1 with `sensor_data`=0x01020304 after reset, `tx_ready`=1 → `ack` one cycle; bytes A5 00 01 02 03 04 0A on 7 consecutive cycles; then `frame_done`, `seq`=0x01.
- Backpressure: same stimulus with `tx_ready`=0 for 3 cycles while byte 0x02 is presented → `tx_data` holds 0x02 and `tx_valid` stays 1 throughout; the final byte sequence is unchanged.
- Checksum wrap: `sensor_data`=0xFFFFFFFF with `seq`=0x02 → checksum byte 0xFE (1022 mod 256).
- Sequence wrap: 257 back-to-back frames → frame 256 carries seq 0xFF; frame 257 carries seq 0x00.
- Held `sensor_done`: keep `sensor_done`=1 for 20 cycles → exactly one `ack` per frame, and no capture while `busy`=1.
- Reset mid-frame: assert `rst` during PAYLOAD → next cycle `tx_valid`=0, `busy`=0, no `frame_done`; the next frame starts with seq 0x00.
